// File: rtl/candy_opfetch_pkg.sv
// Shared widths, enable levels and FSM encodings for the candy operand-fetch slice.
package candy_opfetch_pkg;

    localparam int unsigned REG_BUS      = 32;
    localparam int unsigned REG_ADDR_BUS = 5;
    localparam int unsigned REG_NUM      = 32;
    localparam logic        READ_ENABLE  = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HAZ  = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    typedef struct packed {
        logic use1;
        logic use2;
        logic wen;
    } ctl_t;

endpackage

// File: rtl/candy_opfetch_if.sv
// Bundle of the ID, register-file, writeback and EX signals seen by candy_opfetch.
interface candy_opfetch_if
    import candy_opfetch_pkg::*;
#(
    parameter int unsigned REG_W  = REG_BUS,
    parameter int unsigned ADDR_W = REG_ADDR_BUS
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic              in_use1;
    logic              in_use2;
    logic [ADDR_W-1:0] in_rd;
    logic              in_wen;
    logic              rf_re1;
    logic [ADDR_W-1:0] rf_raddr1;
    logic              rf_re2;
    logic [ADDR_W-1:0] rf_raddr2;
    logic [REG_W-1:0]  rf_rdata1;
    logic [REG_W-1:0]  rf_rdata2;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic              out_valid;
    logic              out_ready;
    logic [REG_W-1:0]  out_op1;
    logic [REG_W-1:0]  out_op2;
    logic [ADDR_W-1:0] out_rd;
    logic              out_wen;

    modport slave (
        input  flush, in_valid, in_rs1, in_rs2, in_use1, in_use2, in_rd, in_wen,
        input  rf_rdata1, rf_rdata2, wb_valid, wb_rd, out_ready,
        output in_ready, rf_re1, rf_raddr1, rf_re2, rf_raddr2,
        output out_valid, out_op1, out_op2, out_rd, out_wen
    );

    modport master (
        output flush, in_valid, in_rs1, in_rs2, in_use1, in_use2, in_rd, in_wen,
        output rf_rdata1, rf_rdata2, wb_valid, wb_rd, out_ready,
        input  in_ready, rf_re1, rf_raddr1, rf_re2, rf_raddr2,
        input  out_valid, out_op1, out_op2, out_rd, out_wen
    );

endinterface

// File: rtl/candy_opfetch_scoreboard.sv
// Per-register busy bits with one set port, two clear ports and three lookups.
// Lookups see the writeback clear of the same cycle, matching regfile forwarding.
module candy_scoreboard
    import candy_opfetch_pkg::*;
#(
    parameter int unsigned NREGS  = REG_NUM,
    parameter int unsigned ADDR_W = REG_ADDR_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              wb_clr_en,
    input  logic [ADDR_W-1:0] wb_clr_addr,
    input  logic              kill_clr_en,
    input  logic [ADDR_W-1:0] kill_clr_addr,
    input  logic [ADDR_W-1:0] look_addr1,
    input  logic [ADDR_W-1:0] look_addr2,
    input  logic [ADDR_W-1:0] look_addr3,
    output logic              look_busy1,
    output logic              look_busy2,
    output logic              look_busy3
);

    localparam logic [NREGS-1:0] KEEP = {{(NREGS-1){1'b1}}, 1'b0};

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] wb_mask;
    logic [NREGS-1:0] kill_mask;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] eff_busy;

    always_comb begin
        wb_mask   = '0;
        kill_mask = '0;
        set_mask  = '0;
        if (wb_clr_en)   wb_mask[wb_clr_addr]     = 1'b1;
        if (kill_clr_en) kill_mask[kill_clr_addr] = 1'b1;
        if (set_en)      set_mask[set_addr]       = 1'b1;
        eff_busy   = busy_q & ~wb_mask;
        look_busy1 = eff_busy[look_addr1];
        look_busy2 = eff_busy[look_addr2];
        look_busy3 = eff_busy[look_addr3];
    end

    // Set is applied after both clears so an issue beats a same-cycle retire; bit 0 never sticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= ((eff_busy & ~kill_mask) | set_mask) & KEEP;
        end
    end

endmodule

// File: rtl/candy_opfetch.sv
// Operand-fetch stage: hazard-checks decoded instructions against the busy scoreboard,
// reads the register file and hands operands to EX over valid/ready.
module candy_opfetch
    import candy_opfetch_pkg::*;
#(
    parameter int unsigned REG_W  = REG_BUS,
    parameter int unsigned ADDR_W = REG_ADDR_BUS,
    parameter int unsigned NREGS  = REG_NUM
) (
    input  logic            clk,
    input  logic            rst,
    candy_opfetch_if.slave  bus
);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [ADDR_W-1:0] rd_q;
    ctl_t              ctl_q;
    logic [REG_W-1:0]  op1_q;
    logic [REG_W-1:0]  op2_q;
    logic [ADDR_W-1:0] ord_q;
    logic              owen_q;

    logic busy1;
    logic busy2;
    logic busy3;
    logic stall;
    logic issue;
    logic kill_clr;

    candy_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .set_en        (issue & ctl_q.wen),
        .set_addr      (rd_q),
        .wb_clr_en     (bus.wb_valid),
        .wb_clr_addr   (bus.wb_rd),
        .kill_clr_en   (kill_clr),
        .kill_clr_addr (rd_q),
        .look_addr1    (rs1_q),
        .look_addr2    (rs2_q),
        .look_addr3    (rd_q),
        .look_busy1    (busy1),
        .look_busy2    (busy2),
        .look_busy3    (busy3)
    );

    assign stall = (ctl_q.use1 & busy1) | (ctl_q.use2 & busy2) | (ctl_q.wen & busy3);

    // A flush in HAZ suppresses the issue itself, so only READ/OUT need the busy bit undone.
    assign issue    = (state_q == ST_HAZ) & ~stall & ~bus.flush;
    assign kill_clr = bus.flush & ctl_q.wen & ((state_q == ST_READ) | (state_q == ST_OUT));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.in_valid)  state_d = ST_HAZ;
            ST_HAZ:  if (!stall)        state_d = ST_READ;
            ST_READ:                    state_d = ST_OUT;
            ST_OUT:  if (bus.out_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
        if (bus.flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctl_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            ord_q   <= '0;
            owen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.in_valid && !bus.flush) begin
                rs1_q <= bus.in_rs1;
                rs2_q <= bus.in_rs2;
                rd_q  <= bus.in_rd;
                ctl_q <= '{use1: bus.in_use1, use2: bus.in_use2, wen: bus.in_wen};
            end
            if (state_q == ST_READ) begin
                op1_q  <= ctl_q.use1 ? bus.rf_rdata1 : '0;
                op2_q  <= ctl_q.use2 ? bus.rf_rdata2 : '0;
                ord_q  <= rd_q;
                owen_q <= ctl_q.wen;
            end
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.rf_re1    = (issue && ctl_q.use1) ? READ_ENABLE : ~READ_ENABLE;
    assign bus.rf_re2    = (issue && ctl_q.use2) ? READ_ENABLE : ~READ_ENABLE;
    assign bus.rf_raddr1 = issue ? rs1_q : '0;
    assign bus.rf_raddr2 = issue ? rs2_q : '0;
    assign bus.out_valid = (state_q == ST_OUT) & ~bus.flush;
    assign bus.out_op1   = op1_q;
    assign bus.out_op2   = op2_q;
    assign bus.out_rd    = ord_q;
    assign bus.out_wen   = owen_q;

endmodule

// File: tb/tb_candy_opfetch.sv
// Self-checking bench for candy_opfetch: table-driven no-hazard vectors plus hazard,
// backpressure, flush and reset sequences, with an output scoreboard queue.
module tb_candy_opfetch;
    import candy_opfetch_pkg::*;

    localparam int unsigned RW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    candy_opfetch_if #(.REG_W(RW), .ADDR_W(AW)) bus ();

    candy_opfetch #(.REG_W(RW), .ADDR_W(AW), .NREGS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NR-1:0] busy;
    assign busy = dut.u_sb.busy_q;

    typedef struct {
        logic [RW-1:0] op1;
        logic [RW-1:0] op2;
        logic [AW-1:0] rd;
        logic          wen;
    } exp_t;

    typedef struct {
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          u1;
        logic          u2;
        logic [AW-1:0] rd;
        logic          wen;
        logic [RW-1:0] e1;
        logic [RW-1:0] e2;
        logic          eb;
    } vec_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [RW-1:0] rf1(input logic [AW-1:0] a);
        return 32'h1000_0000 + 32'(a) * 32'h0001_0203;
    endfunction

    function automatic logic [RW-1:0] rf2(input logic [AW-1:0] a);
        return 32'h2000_0000 + 32'(a) * 32'h0003_0405;
    endfunction

    // Register file model: data one cycle after the request, garbage when not requested.
    always @(posedge clk) begin
        bus.rf_rdata1 <= (bus.rf_re1 === 1'b1) ? rf1(bus.rf_raddr1) : 32'hDEAD_BEEF;
        bus.rf_rdata2 <= (bus.rf_re2 === 1'b1) ? rf2(bus.rf_raddr2) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample mid-cycle, after inputs settle and before the next rising edge.
    always begin
        exp_t e;
        @(negedge clk);
        #3;
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got output rd=%0d, expected no output", bus.out_rd);
            end else begin
                e = q.pop_front();
                chk("sb_op1", bus.out_op1, e.op1);
                chk("sb_op2", bus.out_op2, e.op2);
                chk("sb_rd",  bus.out_rd,  e.rd);
                chk("sb_wen", bus.out_wen, e.wen);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic u1, input logic u2,
                         input logic [AW-1:0] rd, input logic wen,
                         input logic [RW-1:0] e1, input logic [RW-1:0] e2);
        exp_t e;
        chk("in_ready_at_issue", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_use1  = u1;
        bus.in_use2  = u2;
        bus.in_rd    = rd;
        bus.in_wen   = wen;
        e.op1 = e1;
        e.op2 = e2;
        e.rd  = rd;
        e.wen = wen;
        q.push_back(e);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL wait_out_timeout: got no out_valid in %0d cycles, expected out_valid", n);
        end
    endtask

    task automatic retire(input logic [AW-1:0] rd);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        step();
        bus.wb_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int   n;

        tbl[0] = '{5'd1,  5'd2,  1'b1, 1'b1, 5'd3,  1'b1, rf1(5'd1),  rf2(5'd2),  1'b1};
        tbl[1] = '{5'd4,  5'd6,  1'b1, 1'b0, 5'd8,  1'b1, rf1(5'd4),  32'h0,      1'b1};
        tbl[2] = '{5'd10, 5'd11, 1'b0, 1'b1, 5'd12, 1'b1, 32'h0,      rf2(5'd11), 1'b1};
        tbl[3] = '{5'd13, 5'd14, 1'b0, 1'b0, 5'd0,  1'b0, 32'h0,      32'h0,      1'b0};
        tbl[4] = '{5'd31, 5'd30, 1'b1, 1'b1, 5'd0,  1'b1, rf1(5'd31), rf2(5'd30), 1'b0};
        tbl[5] = '{5'd20, 5'd21, 1'b1, 1'b1, 5'd22, 1'b0, rf1(5'd20), rf2(5'd21), 1'b0};

        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_use1   = 1'b0;
        bus.in_use2   = 1'b0;
        bus.in_rd     = '0;
        bus.in_wen    = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_op1",   bus.out_op1,   0);
        chk("rst_out_op2",   bus.out_op2,   0);
        chk("rst_out_rd",    bus.out_rd,    0);
        chk("rst_out_wen",   bus.out_wen,   0);
        chk("rst_rf_re1",    bus.rf_re1,    0);
        chk("rst_rf_re2",    bus.rf_re2,    0);
        chk("rst_busy",      busy,          0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd, tbl[i].wen,
                  tbl[i].e1, tbl[i].e2);
            chk("t_re1",    bus.rf_re1,    tbl[i].u1);
            chk("t_re2",    bus.rf_re2,    tbl[i].u2);
            chk("t_raddr1", bus.rf_raddr1, tbl[i].rs1);
            chk("t_raddr2", bus.rf_raddr2, tbl[i].rs2);
            wait_out(n);
            chk("t_latency",  n + 1,           3);
            chk("t_re1_idle", bus.rf_re1,      0);
            chk("t_busy_rd",  busy[tbl[i].rd], tbl[i].eb);
            step();
            chk("t_in_ready", bus.in_ready, 1);
            if (tbl[i].eb) retire(tbl[i].rd);
            chk("t_busy_clr", busy, 0);
        end

        // RAW: retire of r5 releases the stalled reader in the same cycle
        issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, rf1(5'd1), rf2(5'd2));
        wait_out(n);
        step();
        chk("raw_busy5", busy[5], 1);
        issue(5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b0, rf1(5'd5), rf2(5'd3));
        for (int k = 0; k < 3; k++) begin
            chk("raw_stall_re1", bus.rf_re1,   0);
            chk("raw_stall_rdy", bus.in_ready, 0);
            step();
        end
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd5;
        #1;
        chk("raw_issue_re1",   bus.rf_re1,    1);
        chk("raw_issue_raddr", bus.rf_raddr1, 5);
        step();
        bus.wb_valid = 1'b0;
        wait_out(n);
        chk("raw_read_to_out", n, 1);
        step();
        chk("raw_busy_clr", busy, 0);

        // WAW: retire and re-set of r7 in one cycle leaves it busy
        issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 32'h0, 32'h0);
        wait_out(n);
        step();
        issue(5'd3, 5'd4, 1'b0, 1'b0, 5'd7, 1'b1, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            chk("waw_stall_valid", bus.out_valid, 0);
            chk("waw_stall_rdy",   bus.in_ready,  0);
            step();
        end
        retire(5'd7);
        chk("waw_set_wins", busy[7], 1);
        wait_out(n);
        step();
        retire(5'd7);
        chk("waw_busy_clr", busy, 0);
        issue(5'd3, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
        wait_out(n);
        chk("zero_op1", bus.out_op1, 0);
        chk("zero_op2", bus.out_op2, 0);
        step();

        // Backpressure holds everything steady
        bus.out_ready = 1'b0;
        issue(5'd8, 5'd9, 1'b1, 1'b1, 5'd11, 1'b1, rf1(5'd8), rf2(5'd9));
        wait_out(n);
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid",  bus.out_valid, 1);
            chk("bp_op1",    bus.out_op1,   rf1(5'd8));
            chk("bp_op2",    bus.out_op2,   rf2(5'd9));
            chk("bp_rd",     bus.out_rd,    11);
            chk("bp_in_rdy", bus.in_ready,  0);
            chk("bp_busy",   busy[11],      1);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_release", bus.in_ready, 1);
        retire(5'd11);

        // Flush in OUT undoes the held instruction's busy bit
        bus.out_ready = 1'b0;
        issue(5'd1, 5'd1, 1'b1, 1'b0, 5'd9, 1'b1, rf1(5'd1), 32'h0);
        wait_out(n);
        chk("fo_busy9", busy[9], 1);
        bus.flush = 1'b1;
        #1;
        chk("fo_valid_masked", bus.out_valid, 0);
        step();
        bus.flush = 1'b0;
        chk("fo_in_ready", bus.in_ready,  1);
        chk("fo_valid",    bus.out_valid, 0);
        chk("fo_busy",     busy,          0);
        void'(q.pop_back());
        bus.out_ready = 1'b1;

        // Flush in HAZ leaves the scoreboard alone
        issue(5'd2, 5'd3, 1'b1, 1'b1, 5'd12, 1'b1, rf1(5'd2), rf2(5'd3));
        wait_out(n);
        step();
        issue(5'd12, 5'd3, 1'b1, 1'b0, 5'd13, 1'b1, rf1(5'd12), 32'h0);
        step();
        chk("fh_stalled", bus.in_ready, 0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("fh_busy",     busy,         32'h0000_1000);
        chk("fh_in_ready", bus.in_ready, 1);
        void'(q.pop_back());
        retire(5'd12);
        chk("fh_busy_clr", busy, 0);

        // Reset in READ drops the instruction and every busy bit
        issue(5'd4, 5'd5, 1'b1, 1'b1, 5'd14, 1'b1, rf1(5'd4), rf2(5'd5));
        step();
        chk("rr_busy14", busy[14], 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        chk("rr_in_ready", bus.in_ready,  1);
        chk("rr_valid",    bus.out_valid, 0);
        chk("rr_op1",      bus.out_op1,   0);
        chk("rr_op2",      bus.out_op2,   0);
        chk("rr_rd",       bus.out_rd,    0);
        chk("rr_wen",      bus.out_wen,   0);
        chk("rr_re1",      bus.rf_re1,    0);
        chk("rr_busy",     busy,          0);

        // Writeback of r0 or of a non-busy register changes nothing
        issue(5'd1, 5'd2, 1'b0, 1'b0, 5'd15, 1'b1, 32'h0, 32'h0);
        wait_out(n);
        step();
        retire(5'd0);
        chk("wb0_busy", busy, 32'h0000_8000);
        retire(5'd16);
        chk("wb16_busy", busy, 32'h0000_8000);
        retire(5'd15);
        chk("wb15_clr", busy, 0);

        step();
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
